// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS controller: state codes, ALUOp codes,
// opcode/funct values and datapath mux selects.
package mc_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IF  = 3'd0,
    S_ID  = 3'd1,
    S_EX  = 3'd2,
    S_MEM = 3'd3,
    S_WB  = 3'd4
  } state_t;

  localparam logic [2:0] ALU_ADD   = 3'd0;
  localparam logic [2:0] ALU_BEQ   = 3'd1;
  localparam logic [2:0] ALU_RTYPE = 3'd2;
  localparam logic [2:0] ALU_ADDIU = 3'd3;
  localparam logic [2:0] ALU_ANDI  = 3'd4;
  localparam logic [2:0] ALU_SLTI  = 3'd5;
  localparam logic [2:0] ALU_SLTIU = 3'd6;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] F_SLL  = 6'h00;
  localparam logic [5:0] F_SRL  = 6'h02;
  localparam logic [5:0] F_SRA  = 6'h03;
  localparam logic [5:0] F_JR   = 6'h08;
  localparam logic [5:0] F_JALR = 6'h09;
  localparam logic [5:0] F_ALU_LO = 6'h20;
  localparam logic [5:0] F_ALU_HI = 6'h2B;

  localparam logic IORD_PC     = 1'b0;
  localparam logic IORD_ALUOUT = 1'b1;

  localparam logic [1:0] M2R_MDR    = 2'b00;
  localparam logic [1:0] M2R_ALUOUT = 2'b01;
  localparam logic [1:0] M2R_PC     = 2'b10;

  localparam logic [1:0] DST_RT = 2'b00;
  localparam logic [1:0] DST_RD = 2'b01;
  localparam logic [1:0] DST_RA = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_A     = 2'b01;
  localparam logic [1:0] SRCA_SHAMT = 2'b10;

  localparam logic [1:0] SRCB_B      = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] PCS_ALU    = 2'b00;
  localparam logic [1:0] PCS_ALUOUT = 2'b01;
  localparam logic [1:0] PCS_JUMP   = 2'b10;

  // Loads, stores, addi and lui all just add; the rest use their own ALU code.
  function automatic logic [2:0] imm_alu_op(input logic [5:0] op);
    case (op)
      OP_ADDIU: imm_alu_op = ALU_ADDIU;
      OP_ANDI:  imm_alu_op = ALU_ANDI;
      OP_SLTI:  imm_alu_op = ALU_SLTI;
      OP_SLTIU: imm_alu_op = ALU_SLTIU;
      default:  imm_alu_op = ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/mc_ctrl_decode.sv
// Combinational instruction classifier: turns OpCode/Funct into the class flags
// the controller sequences on, and flags anything it cannot decode.
module mc_ctrl_decode (
  input  logic [5:0] OpCode,
  input  logic [5:0] Funct,
  output logic       is_rtype,
  output logic       is_imm,
  output logic       is_load,
  output logic       is_store,
  output logic       is_branch,
  output logic       is_jump,
  output logic       is_link,
  output logic       is_shift,
  output logic       illegal
);
  import mc_ctrl_pkg::*;

  logic funct_shift;
  logic funct_ok;

  assign funct_shift = (Funct == F_SLL) || (Funct == F_SRL) || (Funct == F_SRA);
  assign funct_ok    = funct_shift || (Funct == F_JR) || (Funct == F_JALR) ||
                       ((Funct >= F_ALU_LO) && (Funct <= F_ALU_HI));

  always_comb begin
    is_rtype  = 1'b0;
    is_imm    = 1'b0;
    is_load   = 1'b0;
    is_store  = 1'b0;
    is_branch = 1'b0;
    is_jump   = 1'b0;
    is_link   = 1'b0;
    is_shift  = 1'b0;
    illegal   = 1'b0;
    case (OpCode)
      OP_RTYPE: begin
        if (funct_ok) begin
          is_rtype = 1'b1;
          is_shift = funct_shift;
          is_jump  = (Funct == F_JR) || (Funct == F_JALR);
          is_link  = (Funct == F_JALR);
        end else begin
          illegal = 1'b1;
        end
      end
      OP_J:   is_jump = 1'b1;
      OP_JAL: begin
        is_jump = 1'b1;
        is_link = 1'b1;
      end
      OP_BEQ: is_branch = 1'b1;
      OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_LUI: is_imm = 1'b1;
      OP_LW: begin
        is_imm  = 1'b1;
        is_load = 1'b1;
      end
      OP_SW: begin
        is_imm   = 1'b1;
        is_store = 1'b1;
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/mc_ctrl_hs.sv
// Multi-cycle MIPS control unit with mem_req/mem_ready handshake, retire counter and
// illegal-op reporting; MC_CTRL_MEM_TIMEOUT_EN adds a stall-timeout memory fault.
module mc_ctrl_hs #(
  parameter int ALUOP_W     = 4,
  parameter int RET_CNT_W   = 32,
  parameter int MEM_TIMEOUT = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [5:0]           OpCode,
  input  logic [5:0]           Funct,
  input  logic                 mem_ready,
  output logic                 mem_req,
  output logic                 PCWrite,
  output logic                 PCWriteCond,
  output logic                 MemWrite,
  output logic                 MemRead,
  output logic                 IRWrite,
  output logic                 RegWrite,
  output logic                 ExtOp,
  output logic                 LuiOp,
  output logic                 IorD,
  output logic [1:0]           MemtoReg,
  output logic [1:0]           RegDst,
  output logic [1:0]           ALUSrcA,
  output logic [1:0]           ALUSrcB,
  output logic [ALUOP_W-1:0]   ALUOp,
  output logic [1:0]           PCSource,
  output logic [2:0]           state,
  output logic                 illegal_op,
  output logic                 retire,
  output logic [RET_CNT_W-1:0] retired_cnt,
  output logic                 mem_fault
);
  import mc_ctrl_pkg::*;

  state_t     state_q, state_d;
  logic [2:0] alu_op;
  logic       timeout_hit;
  logic       is_rtype, is_imm, is_load, is_store, is_branch;
  logic       is_jump, is_link, is_shift, illegal;

  mc_ctrl_decode u_decode (
    .OpCode   (OpCode),
    .Funct    (Funct),
    .is_rtype (is_rtype),
    .is_imm   (is_imm),
    .is_load  (is_load),
    .is_store (is_store),
    .is_branch(is_branch),
    .is_jump  (is_jump),
    .is_link  (is_link),
    .is_shift (is_shift),
    .illegal  (illegal)
  );

`ifdef MC_CTRL_MEM_TIMEOUT_EN
  localparam int TO_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(MEM_TIMEOUT - 1);

  logic [TO_W-1:0] to_cnt;
  logic            mem_stall;

  assign mem_stall   = ((state_q == S_IF) || (state_q == S_MEM)) && !mem_ready;
  assign timeout_hit = mem_stall && (to_cnt == TO_LAST);

  // Any state change other than a timeout only happens on mem_ready, so clearing
  // on "not stalling" also covers the state-change case.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      to_cnt <= '0;
    else if (mem_stall && !timeout_hit)
      to_cnt <= to_cnt + 1'b1;
    else
      to_cnt <= '0;
  end
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^MEM_TIMEOUT;
  assign timeout_hit        = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IF;
      retired_cnt <= '0;
    end else begin
      state_q <= state_d;
      if (retire)
        retired_cnt <= retired_cnt + 1'b1;
    end
  end

  always_comb begin
    state_d     = S_IF;
    mem_req     = 1'b0;
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    MemWrite    = 1'b0;
    MemRead     = 1'b0;
    IRWrite     = 1'b0;
    RegWrite    = 1'b0;
    ExtOp       = 1'b0;
    LuiOp       = 1'b0;
    IorD        = IORD_PC;
    MemtoReg    = M2R_MDR;
    RegDst      = DST_RT;
    ALUSrcA     = SRCA_PC;
    ALUSrcB     = SRCB_B;
    alu_op      = ALU_ADD;
    PCSource    = PCS_ALU;
    illegal_op  = 1'b0;
    retire      = 1'b0;
    mem_fault   = timeout_hit;
    case (state_q)
      S_IF: begin
        mem_req = 1'b1;
        MemRead = 1'b1;
        ALUSrcB = SRCB_FOUR;
        PCWrite = mem_ready;
        IRWrite = mem_ready;
        state_d = mem_ready ? S_ID : S_IF;
      end
      S_ID: begin
        ALUSrcB = SRCB_IMM_SH;
        ExtOp   = 1'b1;
        state_d = S_EX;
      end
      S_EX: begin
        if (illegal) begin
          illegal_op = 1'b1;
        end else if (is_rtype) begin
          ALUSrcA = is_shift ? SRCA_SHAMT : SRCA_A;
          if (is_jump) begin
            PCWrite  = 1'b1;
            RegWrite = is_link;
            RegDst   = is_link ? DST_RD : DST_RT;
            MemtoReg = is_link ? M2R_PC : M2R_MDR;
            retire   = 1'b1;
          end else begin
            alu_op  = ALU_RTYPE;
            state_d = S_WB;
          end
        end else if (is_imm) begin
          ALUSrcA = SRCA_A;
          ALUSrcB = SRCB_IMM;
          ExtOp   = (OpCode != OP_ANDI);
          LuiOp   = (OpCode == OP_LUI);
          alu_op  = imm_alu_op(OpCode);
          state_d = (is_load || is_store) ? S_MEM : S_WB;
        end else if (is_branch) begin
          PCWriteCond = 1'b1;
          ALUSrcA     = SRCA_A;
          alu_op      = ALU_BEQ;
          PCSource    = PCS_ALUOUT;
          retire      = 1'b1;
        end else begin
          PCWrite  = 1'b1;
          PCSource = PCS_JUMP;
          RegWrite = is_link;
          RegDst   = is_link ? DST_RA : DST_RT;
          MemtoReg = is_link ? M2R_PC : M2R_MDR;
          retire   = 1'b1;
        end
      end
      S_MEM: begin
        mem_req  = 1'b1;
        IorD     = IORD_ALUOUT;
        MemRead  = is_load;
        MemWrite = is_store;
        if (mem_ready) begin
          state_d = is_load ? S_WB : S_IF;
          retire  = !is_load;
        end else begin
          state_d = timeout_hit ? S_IF : S_MEM;
        end
      end
      S_WB: begin
        RegWrite = 1'b1;
        RegDst   = is_rtype ? DST_RD : DST_RT;
        MemtoReg = is_load ? M2R_MDR : M2R_ALUOUT;
        retire   = 1'b1;
      end
      default: state_d = S_IF;
    endcase

    // Reset must silence the memory port and every write enable right away.
    if (reset) begin
      mem_req     = 1'b0;
      PCWrite     = 1'b0;
      PCWriteCond = 1'b0;
      MemWrite    = 1'b0;
      MemRead     = 1'b0;
      IRWrite     = 1'b0;
      RegWrite    = 1'b0;
      ExtOp       = 1'b0;
      LuiOp       = 1'b0;
      IorD        = 1'b0;
      MemtoReg    = 2'b00;
      RegDst      = 2'b00;
      ALUSrcA     = 2'b00;
      ALUSrcB     = 2'b00;
      alu_op      = 3'd0;
      PCSource    = 2'b00;
      illegal_op  = 1'b0;
      retire      = 1'b0;
      mem_fault   = 1'b0;
    end
  end

  assign ALUOp = ALUOP_W'(alu_op);
  assign state = reset ? 3'd0 : state_q;

endmodule

// File: tb/tb_mc_ctrl_hs.sv
// Directed bench for mc_ctrl_hs: reset, ALU/load/branch/jump flows with memory waits,
// illegal decode, reset mid-access and (with MC_CTRL_MEM_TIMEOUT_EN) the memory timeout.
module tb_mc_ctrl_hs;

  logic        clk = 1'b0;
  logic        reset;
  logic [5:0]  OpCode, Funct;
  logic        mem_ready;
  logic        mem_req, PCWrite, PCWriteCond, MemWrite, MemRead, IRWrite, RegWrite;
  logic        ExtOp, LuiOp, IorD;
  logic [1:0]  MemtoReg, RegDst, ALUSrcA, ALUSrcB, PCSource;
  logic [3:0]  ALUOp;
  logic [2:0]  state;
  logic        illegal_op, retire, mem_fault;
  logic [31:0] retired_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mc_ctrl_hs #(.ALUOP_W(4), .RET_CNT_W(32), .MEM_TIMEOUT(4)) dut (
    .clk(clk), .reset(reset), .OpCode(OpCode), .Funct(Funct), .mem_ready(mem_ready),
    .mem_req(mem_req), .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .MemWrite(MemWrite),
    .MemRead(MemRead), .IRWrite(IRWrite), .RegWrite(RegWrite), .ExtOp(ExtOp), .LuiOp(LuiOp),
    .IorD(IorD), .MemtoReg(MemtoReg), .RegDst(RegDst), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ALUOp(ALUOp), .PCSource(PCSource), .state(state), .illegal_op(illegal_op),
    .retire(retire), .retired_cnt(retired_cnt), .mem_fault(mem_fault)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic settle;
    #2;
  endtask

  task automatic test_reset;
    reset = 1'b1; mem_ready = 1'b1; OpCode = 6'h08; Funct = 6'h00;
    #3;
    checks++; if (state !== 3'd0) begin errors++; $display("FAIL rst_state got %0d exp 0", state); end
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL rst_mem_req got %0b exp 0", mem_req); end
    checks++; if (MemRead !== 1'b0 || PCWrite !== 1'b0) begin errors++; $display("FAIL rst_enables got %0b%0b exp 00", MemRead, PCWrite); end
    checks++; if (retired_cnt !== 32'd0) begin errors++; $display("FAIL rst_cnt got %0d exp 0", retired_cnt); end
    tick;
    reset = 1'b0;
    settle;
    checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL rel_mem_req got %0b exp 1", mem_req); end
  endtask

  task automatic test_addi;
    OpCode = 6'h08; mem_ready = 1'b1;
    checks++; if (IRWrite !== 1'b1 || PCWrite !== 1'b1 || ALUSrcB !== 2'd1) begin errors++; $display("FAIL addi_if got irw=%0b pcw=%0b srcb=%0d exp 1 1 1", IRWrite, PCWrite, ALUSrcB); end
    tick; settle;
    checks++; if (state !== 3'd1 || ALUSrcB !== 2'd3 || ExtOp !== 1'b1) begin errors++; $display("FAIL addi_id got st=%0d srcb=%0d ext=%0b exp 1 3 1", state, ALUSrcB, ExtOp); end
    tick; settle;
    checks++; if (state !== 3'd2 || ALUSrcA !== 2'd1 || ALUSrcB !== 2'd2 || ALUOp !== 4'd0) begin errors++; $display("FAIL addi_ex got st=%0d a=%0d b=%0d op=%0d exp 2 1 2 0", state, ALUSrcA, ALUSrcB, ALUOp); end
    tick; settle;
    checks++; if (state !== 3'd4 || RegWrite !== 1'b1 || RegDst !== 2'd0 || MemtoReg !== 2'd1 || retire !== 1'b1) begin errors++; $display("FAIL addi_wb got st=%0d rw=%0b dst=%0d m2r=%0d ret=%0b exp 4 1 0 1 1", state, RegWrite, RegDst, MemtoReg, retire); end
    tick; settle;
    checks++; if (state !== 3'd0 || retired_cnt !== 32'd1) begin errors++; $display("FAIL addi_done got st=%0d cnt=%0d exp 0 1", state, retired_cnt); end
  endtask

  task automatic test_lw_wait;
    logic       rdy  [10] = '{0, 0, 1, 1, 1, 0, 0, 0, 1, 1};
    logic [2:0] exp_st[10] = '{0, 0, 0, 1, 2, 3, 3, 3, 3, 4};
    logic       exp_ir[10] = '{0, 0, 1, 0, 0, 0, 0, 0, 0, 0};
    OpCode = 6'h23;
    for (int i = 0; i < 10; i++) begin
      mem_ready = rdy[i];
      settle;
      checks++; if (state !== exp_st[i]) begin errors++; $display("FAIL lw_state[%0d] got %0d exp %0d", i, state, exp_st[i]); end
      checks++; if (IRWrite !== exp_ir[i] || PCWrite !== exp_ir[i]) begin errors++; $display("FAIL lw_irw_pcw[%0d] got %0b%0b exp %0b%0b", i, IRWrite, PCWrite, exp_ir[i], exp_ir[i]); end
      if (exp_st[i] == 3'd3) begin
        checks++; if (mem_req !== 1'b1 || IorD !== 1'b1 || MemRead !== 1'b1 || MemWrite !== 1'b0) begin errors++; $display("FAIL lw_mem[%0d] got req=%0b iord=%0b rd=%0b wr=%0b exp 1 1 1 0", i, mem_req, IorD, MemRead, MemWrite); end
      end
      if (i == 9) begin
        checks++; if (RegWrite !== 1'b1 || MemtoReg !== 2'd0 || RegDst !== 2'd0) begin errors++; $display("FAIL lw_wb got rw=%0b m2r=%0d dst=%0d exp 1 0 0", RegWrite, MemtoReg, RegDst); end
      end
      tick;
    end
    mem_ready = 1'b1;
    settle;
    checks++; if (state !== 3'd0 || retired_cnt !== 32'd2) begin errors++; $display("FAIL lw_done got st=%0d cnt=%0d exp 0 2", state, retired_cnt); end
  endtask

  task automatic test_branch_jump;
    OpCode = 6'h04; Funct = 6'h00; mem_ready = 1'b1;
    tick; tick; settle;
    checks++; if (state !== 3'd2 || PCWriteCond !== 1'b1 || PCSource !== 2'd1 || ALUOp !== 4'd1 || PCWrite !== 1'b0 || retire !== 1'b1) begin errors++; $display("FAIL beq_ex got st=%0d pwc=%0b pcs=%0d op=%0d pcw=%0b ret=%0b exp 2 1 1 1 0 1", state, PCWriteCond, PCSource, ALUOp, PCWrite, retire); end
    tick; settle;
    checks++; if (state !== 3'd0 || retired_cnt !== 32'd3) begin errors++; $display("FAIL beq_done got st=%0d cnt=%0d exp 0 3", state, retired_cnt); end
    OpCode = 6'h03;
    tick; tick; settle;
    checks++; if (RegDst !== 2'd2 || MemtoReg !== 2'd2 || PCSource !== 2'd2 || PCWrite !== 1'b1 || RegWrite !== 1'b1) begin errors++; $display("FAIL jal_ex got dst=%0d m2r=%0d pcs=%0d pcw=%0b rw=%0b exp 2 2 2 1 1", RegDst, MemtoReg, PCSource, PCWrite, RegWrite); end
    tick; settle;
    checks++; if (state !== 3'd0 || retired_cnt !== 32'd4) begin errors++; $display("FAIL jal_done got st=%0d cnt=%0d exp 0 4", state, retired_cnt); end
    OpCode = 6'h00; Funct = 6'h00;
    tick; tick; settle;
    checks++; if (ALUSrcA !== 2'd2 || ALUSrcB !== 2'd0 || ALUOp !== 4'd2) begin errors++; $display("FAIL sll_ex got a=%0d b=%0d op=%0d exp 2 0 2", ALUSrcA, ALUSrcB, ALUOp); end
    tick; settle;
    checks++; if (state !== 3'd4 || RegDst !== 2'd1 || MemtoReg !== 2'd1) begin errors++; $display("FAIL sll_wb got st=%0d dst=%0d m2r=%0d exp 4 1 1", state, RegDst, MemtoReg); end
    tick; settle;
    checks++; if (state !== 3'd0 || retired_cnt !== 32'd5) begin errors++; $display("FAIL sll_done got st=%0d cnt=%0d exp 0 5", state, retired_cnt); end
  endtask

  task automatic test_illegal;
    OpCode = 6'h3F; mem_ready = 1'b1;
    tick; tick; settle;
    checks++; if (state !== 3'd2 || illegal_op !== 1'b1 || retire !== 1'b0 || RegWrite !== 1'b0) begin errors++; $display("FAIL ill_op_ex got st=%0d ill=%0b ret=%0b rw=%0b exp 2 1 0 0", state, illegal_op, retire, RegWrite); end
    tick; settle;
    checks++; if (state !== 3'd0 || illegal_op !== 1'b0 || retired_cnt !== 32'd5) begin errors++; $display("FAIL ill_op_next got st=%0d ill=%0b cnt=%0d exp 0 0 5", state, illegal_op, retired_cnt); end
    OpCode = 6'h00; Funct = 6'h01;
    tick; tick; settle;
    checks++; if (illegal_op !== 1'b1 || retire !== 1'b0) begin errors++; $display("FAIL ill_funct_ex got ill=%0b ret=%0b exp 1 0", illegal_op, retire); end
    tick; settle;
    checks++; if (state !== 3'd0 || retired_cnt !== 32'd5) begin errors++; $display("FAIL ill_funct_next got st=%0d cnt=%0d exp 0 5", state, retired_cnt); end
  endtask

  task automatic test_reset_mid_mem;
    OpCode = 6'h2B; Funct = 6'h00; mem_ready = 1'b1;
    tick; tick; tick;
    mem_ready = 1'b0;
    settle;
    checks++; if (state !== 3'd3 || mem_req !== 1'b1 || MemWrite !== 1'b1 || IorD !== 1'b1 || mem_fault !== 1'b0) begin errors++; $display("FAIL sw_mem got st=%0d req=%0b wr=%0b iord=%0b flt=%0b exp 3 1 1 1 0", state, mem_req, MemWrite, IorD, mem_fault); end
    reset = 1'b1;
    #1;
    checks++; if (mem_req !== 1'b0 || MemWrite !== 1'b0 || state !== 3'd0 || retired_cnt !== 32'd0) begin errors++; $display("FAIL sw_rst got req=%0b wr=%0b st=%0d cnt=%0d exp 0 0 0 0", mem_req, MemWrite, state, retired_cnt); end
    tick;
    reset = 1'b0; mem_ready = 1'b1;
    settle;
    checks++; if (state !== 3'd0 || mem_req !== 1'b1 || MemWrite !== 1'b0 || retired_cnt !== 32'd0) begin errors++; $display("FAIL sw_rel got st=%0d req=%0b wr=%0b cnt=%0d exp 0 1 0 0", state, mem_req, MemWrite, retired_cnt); end
  endtask

`ifdef MC_CTRL_MEM_TIMEOUT_EN
  task automatic test_timeout;
    OpCode = 6'h23; mem_ready = 1'b1;
    tick; tick; tick;
    mem_ready = 1'b0;
    for (int s = 1; s <= 4; s++) begin
      settle;
      checks++; if (state !== 3'd3 || mem_fault !== (s == 4) || retire !== 1'b0) begin errors++; $display("FAIL to_stall[%0d] got st=%0d flt=%0b ret=%0b exp 3 %0b 0", s, state, mem_fault, retire, (s == 4)); end
      tick;
    end
    settle;
    checks++; if (state !== 3'd0 || mem_fault !== 1'b0 || retired_cnt !== 32'd0) begin errors++; $display("FAIL to_after got st=%0d flt=%0b cnt=%0d exp 0 0 0", state, mem_fault, retired_cnt); end
  endtask
`endif

  initial begin
    test_reset;
    test_addi;
    test_lw_wait;
    test_branch_jump;
    test_illegal;
    test_reset_mid_mem;
`ifdef MC_CTRL_MEM_TIMEOUT_EN
    test_timeout;
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mc_ctrl_hs.md
# mc_ctrl_hs

Parametrised multi-cycle MIPS control unit with a memory ready/request handshake, replacing the fixed-latency controller in the multi-cycle CPU. It sequences the IF/ID/EX/MEM/WB states and drives every datapath control signal. Instruction and data memory accesses stall until `mem_ready`. It also reports illegal opcodes and counts retired instructions.

## Interface
- ALUOP_W, 4, width of `ALUOp`; must be ≥3.
- RET_CNT_W, 32, width of the retired-instruction counter.
- MEM_TIMEOUT, 16, stall-cycle limit before a memory fault; only used with `MC_CTRL_MEM_TIMEOUT_EN`.
- clk  in  1  clock.
- reset  in  1  reset, asynchronous, active-high.
- OpCode  in  6  IR[31:26]; valid from ID onward.
- Funct  in  6  IR[5:0].
- mem_ready  in  1  memory has completed the current access (read data valid / write accepted).
- mem_req  out  1  memory access requested this cycle.
- PCWrite, PCWriteCond, MemWrite, MemRead, IRWrite, RegWrite, ExtOp, LuiOp  out  1 each  datapath enables.
- IorD  out  1  0 = PC, 1 = ALUOut.
- MemtoReg  out  2  00 = MDR, 01 = ALUOut, 10 = PC (link).
- RegDst  out  2  00 = rt, 01 = rd, 10 = $31.
- ALUSrcA  out  2  00 = PC, 01 = A, 10 = shamt-extended.
- ALUSrcB  out  2  00 = B, 01 = 4, 10 = ImmExt, 11 = ImmExt<<2.
- ALUOp  out  ALUOP_W  encoding: ADD = 0, BEQ = 1, RTYPE = 2, ADDIU = 3, ANDI = 4, SLTI = 5, SLTIU = 6.
- PCSource  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target.
- state  out  3  current state, for debug.
- illegal_op  out  1  one-cycle pulse on an undecodable opcode or funct.
- retire  out  1  one-cycle pulse when an instruction completes.
- retired_cnt  out  RET_CNT_W  count of completed instructions; wraps.
- mem_fault  out  1  one-cycle timeout pulse; tied to 0 without the macro.

## Operation
- State register, 3 bits: IF = 0, ID = 1, EX = 2, MEM = 3, WB = 4. Codes 5–7 go to IF.
- Outputs are combinational from state, OpCode, Funct and mem_ready. Any output not listed for a state is 0.

**IF**
- Asserts mem_req, MemRead; IorD = 0; ALUSrcA = 00; ALUSrcB = 01; ALUOp = ADD; PCSource = 00.
- PCWrite = IRWrite = mem_ready.
- Goes to ID on mem_ready; otherwise stays in IF.

**ID**
- ALUSrcA = 00, ALUSrcB = 11, ExtOp = 1, ALUOp = ADD, so ALUOut holds the branch target.
- Always goes to EX.

**EX, R-type**
- ALUSrcA = 10 for funct 00/02/03, otherwise 01; ALUSrcB = 00.
- jr (08): PCWrite, PCSource = 00, ALUOp = ADD; goes to IF.
- jalr (09): as jr, plus RegWrite, RegDst = 01, MemtoReg = 10; goes to IF.
- Other legal funct (20–2B, 00, 02, 03): ALUOp = RTYPE; goes to WB.

**EX, immediate group** (08, 09, 0A, 0B, 0C, 0F, 23, 2B)
- ALUSrcA = 01, ALUSrcB = 10.
- ExtOp = 0 for andi, otherwise 1. LuiOp = 1 for lui.
- ALUOp = ADD for lw, sw, addi and lui; otherwise the matching code.
- lw and sw go to MEM; the rest go to WB.

**EX, branches and jumps**
- beq (04): PCWriteCond, ALUSrcA = 01, ALUSrcB = 00, ALUOp = BEQ, PCSource = 01; goes to IF.
- j (02): PCWrite, PCSource = 10; goes to IF.
- jal (03): as j, plus RegWrite, RegDst = 10, MemtoReg = 10; goes to IF.

**EX, illegal**
- Any other opcode, or an R-type funct not listed above.
- illegal_op = 1, no writes, no retire; goes to IF.

**MEM**
- mem_req = 1, IorD = 1; MemRead for lw, MemWrite for sw.
- Holds until mem_ready. Then sw goes to IF and lw goes to WB.

**WB**
- RegWrite = 1.
- lw: RegDst = 00, MemtoReg = 00.
- R-type: RegDst = 01, MemtoReg = 01.
- Immediate ops: RegDst = 00, MemtoReg = 01.
- Always goes to IF.

**Retire**
- retire = 1 on every legal transition into IF from EX, MEM or WB.
- retired_cnt increments on retire and wraps to 0.

## Timing
- Reset, asynchronous: state = IF, retired_cnt = 0, timeout counter = 0.
- While reset is high, every output is forced to 0, including mem_req.
- Minimum cycles with zero-wait memory:
  - j, jal, jr, jalr, beq: 3.
  - sw, ALU ops: 4.
  - lw: 5.
- Each wait cycle on mem_ready adds one cycle in IF or MEM.
- mem_req stays high, with stable IorD/MemRead/MemWrite, until the cycle mem_ready is sampled high.
- mem_ready outside IF and MEM is ignored.
- Reset asserted mid-MEM drops mem_req immediately and performs no writes.

## Configuration
- `MC_CTRL_MEM_TIMEOUT_EN` defined:
  - A counter of width $clog2(MEM_TIMEOUT) counts consecutive stall cycles in IF or MEM.
  - On stall cycle MEM_TIMEOUT, mem_fault pulses and the access is abandoned: no IRWrite, RegWrite or retire.
  - The controller then goes to IF, so the same PC is re-fetched.
  - The counter clears on mem_ready or on any state change.
- Macro undefined: the controller waits indefinitely, mem_fault = 0, and no counter is built.

## Structure
- Package `mc_ctrl_pkg`: state codes, ALUOp codes, opcode/funct localparams, and the mux-select encodings.
- Sub-module `mc_ctrl_decode` (combinational): classifies OpCode/Funct into is_rtype, is_imm, is_load, is_store, is_branch, is_jump, is_link, is_shift and illegal.

## Test plan
- addi, mem_ready always 1 → states 0,1,2,4; RegWrite in WB with RegDst = 00, MemtoReg = 01; retired_cnt 0 → 1.
- lw, 2 wait cycles in IF and 3 in MEM → 10 cycles total; IRWrite and PCWrite asserted only in the mem_ready cycle; WB MemtoReg = 00.
- beq in EX → PCWriteCond = 1, PCSource = 01, ALUOp = 1, next state IF; jal → RegDst = 10, MemtoReg = 10, PCSource = 10.
- OpCode 0x3F → illegal_op pulse in EX, no retire, next state IF.
- Reset pulsed during MEM of sw → all outputs 0 immediately, state IF after release, retired_cnt = 0.
- With the macro and MEM_TIMEOUT = 4, mem_ready held 0 in MEM → mem_fault on stall cycle 4, state returns to IF, no retire.
